// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit period, frame length.
// Used by both the TX serializer and the RX side.
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 5208;
   localparam int UART_FRAME_BITS   = 10;
   localparam int UART_DATA_BITS    = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_CLEANUP = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      START_BIT = ST_START,
      DATA_BITS = ST_DATA,
      STOP_BIT  = ST_STOP,
      CLEANUP   = ST_CLEANUP
   } uart_state_e;

   localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte request / completion bundle between the TX register stage
// and the UART serializer.
interface uart_tx_if;

   logic       start;
   logic [7:0] data;
   logic       busy;
   logic       done;

   modport master (
      output start,
      output data,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data,
      output busy,
      output done
   );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and
// flags the last cycle of each bit period.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: one byte per accepted start, LSB first,
// with a one-cycle done pulse after the stop bit.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int CNT_W        = 16
) (
   input  logic      clk,
   input  logic      reset,
   uart_tx_if.slave  bus,
   output logic      tx
);

   uart_state_e state_q;
   uart_state_e state_d;
   logic        tx_q;
   logic        tx_d;
   logic        done_q;
   logic        done_d;
   logic        busy_q;
   logic        busy_d;
   logic [2:0]  idx_q;
   logic [2:0]  idx_d;
   logic [7:0]  shift_q;
   logic [7:0]  shift_d;

   logic        cnt_clr;
   logic        cnt_en;
   logic        bit_end;

   // Counter is held at zero whenever no bit period is being timed.
   assign cnt_clr = (state_q == IDLE) || (state_q == CLEANUP);
   assign cnt_en  = (state_q == START_BIT) ||
                    (state_q == DATA_BITS) ||
                    (state_q == STOP_BIT);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .tick_o (bit_end)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (bus.start) begin
               shift_d = bus.data;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = START_BIT;
            end
         end
         START_BIT: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               idx_d   = 3'd0;
               state_d = DATA_BITS;
            end
         end
         DATA_BITS: begin
            if (bit_end) begin
               if (idx_q == LAST_DATA_IDX) begin
                  tx_d    = 1'b1;
                  state_d = STOP_BIT;
               end else begin
                  // Shift so the next bit is always at shift_q[0].
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[1];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         STOP_BIT: begin
            if (bit_end) begin
               done_d  = 1'b1;
               state_d = CLEANUP;
            end
         end
         CLEANUP: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   assign tx       = tx_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
8N1 UART transmitter that serializes one byte per request onto the TX line. Sits directly downstream of the two-byte TX register stage and consumes its byte/start pulse. It returns a one-cycle completion pulse that the register stage uses as its done_tx input. Drives the board TX pin.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk    input  1  system clock; one clock domain
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; data is valid in the same cycle (driven from upstream done)
data   input  8  byte to send; sampled only on an accepted start
tx     output 1  serial line; idle high
busy   output 1  high while a frame is in progress (state != IDLE)
done   output 1  one-cycle pulse after the stop bit completes (feeds upstream done_tx)

Behaviour:
- Reset, sampled on a clk edge: state=IDLE, tx=1, done=0, busy=0, bit counter=0, bit index=0, shift register=0.
- Reset in the middle of a frame aborts the frame at that edge: tx returns high and no done pulse is issued.
- Reset has priority over start.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP.
- IDLE:
  - tx=1, done=0.
  - On start=1: latch data into the shift register, set tx=0, clear the counter, go to START_BIT.
- START_BIT:
  - Hold tx=0 for CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1.
  - At terminal count: tx=shift[0], index=0, go to DATA_BITS.
- DATA_BITS:
  - Send bits LSB first, each held for CLKS_PER_BIT cycles.
  - At terminal count with index<7: index+1, tx=next bit.
  - At terminal count with index=7: tx=1, go to STOP_BIT.
- STOP_BIT:
  - Hold tx=1 for CLKS_PER_BIT cycles.
  - At terminal count: done<=1, go to CLEANUP.
- CLEANUP: one cycle; done=1 and tx=1; next state is IDLE with done<=0.
- Timing: if start is accepted at edge E, tx is low from E to E+CPB. Data bit k occupies E+(1+k)*CPB to E+(2+k)*CPB. The stop bit occupies E+9*CPB to E+10*CPB. done is high for exactly the cycle E+10*CPB to E+10*CPB+1. busy falls at E+10*CPB+1.
- start while busy=1, including the CLEANUP cycle, is ignored. No queuing. data changes after acceptance do not affect the frame.
- Back-to-back frames:
  - The upstream stage sees done, spends one cycle loading byte two, then pulses start. We are in IDLE by then, so the start is accepted.
  - Minimum gap is the idle-high time between stop bit and next start bit: ≥2 cycles.
- tx, done and busy are registered outputs; no combinational path from inputs.
- Counter compare uses CNT_W bits; no wrap-around occurs within legal CLKS_PER_BIT.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams (3-bit: IDLE=0, START_BIT=1, DATA_BITS=2, STOP_BIT=3, CLEANUP=4);
  - the default CLKS_PER_BIT;
  - the frame length constant (10 bits). The RX side uses the same package.
- One sub-module is natural: uart_baud_counter. It counts to CLKS_PER_BIT-1, produces a terminal-count tick, and has a synchronous clear. The FSM stays in uart_tx_serializer.

Test Plan:
- CLKS_PER_BIT=4, start pulse with data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles. done is a single pulse 40 cycles after the start edge; busy is high for 41 cycles.
- Reset held for 3 cycles -> tx=1, busy=0, done=0. Then start with data=8'h00 -> tx low for 36 cycles (start bit plus 8 data bits), then 4 cycles high, then a done pulse.
- Start again at cycles 10 and 20 of an 8'h3C frame -> second request ignored; exactly one frame and one done pulse. data changed to 8'hFF mid-frame has no effect.
- Drive from the two-byte TX register stage with byte_one=8'h12, byte_two=8'h34 -> two frames transmit 12 then 34. The upstream stage returns to IDLE after the second done. Exactly two done pulses.
- Reset asserted during data bit 3 -> tx=1 from the next edge; no done pulse; busy=0. A fresh start with 8'h81 afterwards transmits a correct frame.
- CLKS_PER_BIT=2 (minimum) with data=8'hFF -> frame is 20 cycles, done at cycle 20, no timing glitch on tx.
